// File: rtl/vga_uart_pkg.sv
// Shared definitions for the pixel-to-UART byte packer.
//   state_e     : byte-serialiser FSM states
//   SYNC_BYTE0/1: default frame sync header bytes
//   PIXEL_BYTES : bytes per pixel word on the wire
package vga_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR0   = 3'd1,
    ST_HDR1   = 3'd2,
    ST_PIX_HI = 3'd3,
    ST_PIX_LO = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE0  = 8'hA5;
  localparam logic [7:0] SYNC_BYTE1  = 8'h5A;
  localparam int         PIXEL_BYTES = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data.
//   clk, srst : clock and synchronous active-high reset
//   wr_en     : write request; accepted when not full, or when a read or
//               flush frees space in the same cycle
//   wr_data   : write word
//   rd_en     : pop the word currently on rd_data (ignored when empty)
//   rd_data   : head-of-queue word, valid while !empty
//   flush     : discard all stored words; beats rd_en, a same-cycle write
//               survives as the only word
//   full/empty/level : occupancy
module sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             rd_do;
  logic             wr_do;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign level = count_q;

  // Reads are read-first: the popped word is the one stored before this
  // edge, even when full and the write lands on the same slot.
  assign rd_do = rd_en && !empty && !flush;
  assign wr_do = wr_en && (!full || rd_do || flush);

  assign rd_data = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_do) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_do) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (flush) begin
        // Head jumps to the write pointer, so a same-cycle write becomes
        // the sole remaining word.
        rd_ptr_q <= wr_ptr_q;
        count_q  <= wr_do ? (AW+1)'(1) : '0;
      end else begin
        if (rd_do) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        count_q <= count_q + (AW+1)'(wr_do) - (AW+1)'(rd_do);
      end
    end
  end

endmodule

// File: rtl/pixel_uart_packer.sv
// Buffers 16-bit pixel words and serialises them MSB-first into a byte
// stream for a UART transmitter, prefixing each frame with a 2-byte sync
// header.
//   CLK, RST      : system clock, synchronous active-high reset
//   i_pixel       : pixel word, high byte sent first
//   i_pixel_valid : one-cycle strobe qualifying i_pixel
//   i_frame_start : one-cycle strobe, flushes queued pixels, requests header
//   o_tx_data     : byte to the UART
//   o_tx_valid    : o_tx_data valid; held with data until i_tx_ready
//   i_tx_ready    : UART accepts o_tx_data this cycle
//   o_fifo_level  : words held in the pixel FIFO
//   o_overflow    : sticky, a pixel was dropped on a full FIFO
module pixel_uart_packer
  import vga_uart_pkg::*;
#(
  parameter  int         PixelBitWidth = 16,
  parameter  int         FifoDepth     = 16,
  parameter  logic [7:0] SyncByte0     = SYNC_BYTE0,
  parameter  logic [7:0] SyncByte1     = SYNC_BYTE1,
  localparam int         LevelW        = $clog2(FifoDepth) + 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [PixelBitWidth-1:0] i_pixel,
  input  logic                     i_pixel_valid,
  input  logic                     i_frame_start,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic [LevelW-1:0]        o_fifo_level,
  output logic                     o_overflow
);

  localparam int ByteW = PixelBitWidth / PIXEL_BYTES;

  state_e                   state_q, state_d;
  logic [PixelBitWidth-1:0] pix_q, pix_d;
  logic                     hdr_pending_q, hdr_pending_d;
  logic                     overflow_q;

  logic                     fifo_pop;
  logic [PixelBitWidth-1:0] fifo_rd_data;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     hdr_now;
  logic                     accept;

  sync_fifo #(
    .WIDTH (PixelBitWidth),
    .DEPTH (FifoDepth)
  ) u_fifo (
    .clk     (CLK),
    .srst    (RST),
    .wr_en   (i_pixel_valid),
    .wr_data (i_pixel),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .flush   (i_frame_start),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (o_fifo_level)
  );

  // A frame start in this very cycle counts as pending, so no word of the
  // old frame can be popped ahead of the new header.
  assign hdr_now = hdr_pending_q || i_frame_start;
  assign accept  = o_tx_valid && i_tx_ready;

  always_comb begin
    state_d       = state_q;
    pix_d         = pix_q;
    hdr_pending_d = hdr_now;
    fifo_pop      = 1'b0;
    o_tx_valid    = 1'b0;
    o_tx_data     = '0;
    case (state_q)
      ST_IDLE: begin
        if (hdr_now) begin
          state_d       = ST_HDR0;
          hdr_pending_d = 1'b0;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          pix_d    = fifo_rd_data;
          state_d  = ST_PIX_HI;
        end
      end
      ST_HDR0: begin
        o_tx_valid = 1'b1;
        o_tx_data  = SyncByte0;
        if (accept) state_d = ST_HDR1;
      end
      ST_HDR1: begin
        o_tx_valid = 1'b1;
        o_tx_data  = SyncByte1;
        if (accept) state_d = ST_IDLE;
      end
      ST_PIX_HI: begin
        o_tx_valid = 1'b1;
        o_tx_data  = pix_q[PixelBitWidth-1 -: ByteW];
        if (accept) begin
          // A new frame abandons the low byte of the interrupted pixel.
          if (hdr_now) begin
            state_d       = ST_HDR0;
            hdr_pending_d = 1'b0;
          end else begin
            state_d = ST_PIX_LO;
          end
        end
      end
      ST_PIX_LO: begin
        o_tx_valid = 1'b1;
        o_tx_data  = pix_q[ByteW-1:0];
        if (accept) begin
          if (hdr_now) begin
            state_d       = ST_HDR0;
            hdr_pending_d = 1'b0;
          end else if (!fifo_empty) begin
            // Back-to-back pop keeps the stream at one byte per cycle.
            fifo_pop = 1'b1;
            pix_d    = fifo_rd_data;
            state_d  = ST_PIX_HI;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      pix_q         <= '0;
      hdr_pending_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_q         <= pix_d;
      hdr_pending_q <= hdr_pending_d;
      // Dropped only when no pop or flush makes room this cycle.
      if (i_pixel_valid && fifo_full && !fifo_pop && !i_frame_start) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign o_overflow = overflow_q;

endmodule
